// File: rtl/ram8.sv
// ram8: eight-word register file with a combinational read port.
// One write port steered by a one-hot decode of address; read data is
// word[address] with zero latency.
// Optional feature: define RAM8_BYPASS_EN to forward in to out whenever
// load is high (write-through of the value about to be stored).
module ram8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] word_q [8];
  logic [WIDTH-1:0] word_d [8];
  logic [7:0]       enable;

  // One-hot write enables; load=0 forces all low even if address is unknown.
  always_comb begin
    enable = '0;
    for (int k = 0; k < 8; k++) begin
      enable[k] = load & (address == 3'(k));
    end
  end

  // Next-state: only the enabled word takes in, the rest hold.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      word_d[k] = word_q[k];
      if (enable[k]) begin
        word_d[k] = in;
      end
    end
  end

  // Storage with asynchronous clear that overrides any coinciding write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        word_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        word_q[k] <= word_d[k];
      end
    end
  end

`ifdef RAM8_BYPASS_EN
  // Read mux with write-through forwarding while load is high.
  always_comb begin
    out = word_q[address];
    if (load) begin
      out = in;
    end
  end
`else
  // Plain 8:1 read mux; stored data only, no in-to-out path.
  always_comb begin
    out = word_q[address];
  end
`endif

endmodule

// File: tb/tb_ram8.sv
// tb_ram8: randomized self-checking bench for ram8 against an array model.
// Honors RAM8_BYPASS_EN for the expected read value while load is high.
module tb_ram8;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         load;
  logic [2:0]   address;
  logic [W-1:0] dout;

  logic [W-1:0] model [8];
  int n_cmp;
  int n_fail;

  ram8 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .load    (load),
    .address (address),
    .out     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the behavioural model.
  function automatic logic [W-1:0] exp_out(input logic [2:0] a, input logic ld,
                                            input logic [W-1:0] d);
`ifdef RAM8_BYPASS_EN
    if (ld) return d;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 8; k++) model[k] = '0;
  endtask

  // Single write cycle; inputs change on the falling edge.
  task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    address = a;
    din     = d;
    load    = 1'b1;
    @(posedge clk);
    if (rst_n) model[a] = d;
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    clear_model();
    #1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_cmp++;
      if (dout !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_initial addr=%0d got=%h exp=0000", a, dout);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_write(3'd3, 16'hBEEF);
    address = 3'd3;
    #1;
    n_cmp++;
    if (dout !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL reset_prewrite got=%h exp=beef", dout);
    end
    // Assert reset mid-cycle, away from any edge.
    #2;
    rst_n = 1'b0;
    clear_model();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #0.5;
      n_cmp++;
      if (dout !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_async addr=%0d got=%h exp=0000", a, dout);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_cmp++;
      if (dout !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_release addr=%0d got=%h exp=0000", a, dout);
      end
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) do_write(3'(k), 16'(16'h1111 * (k + 1)));
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_cmp++;
      if (dout !== 16'(16'h1111 * (a + 1))) begin
        n_fail++;
        $display("FAIL fill addr=%0d got=%h exp=%h", a, dout, 16'(16'h1111 * (a + 1)));
      end
    end
  endtask

  task automatic test_isolation();
    do_write(3'd7, 16'hA5A5);
    do_write(3'd0, 16'h5A5A);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_cmp++;
      if (dout !== model[a]) begin
        n_fail++;
        $display("FAIL isolation addr=%0d got=%h exp=%h", a, dout, model[a]);
      end
    end
    n_cmp++;
    if (model[7] !== 16'hA5A5 || model[3] !== 16'h4444) begin
      n_fail++;
      $display("FAIL isolation_model m7=%h m3=%h exp=a5a5/4444", model[7], model[3]);
    end
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] exp_pre;
    do_write(3'd2, 16'h0042);
`ifdef RAM8_BYPASS_EN
    exp_pre = 16'h1234;
`else
    exp_pre = 16'h0042;
`endif
    @(negedge clk);
    address = 3'd2;
    din     = 16'h1234;
    load    = 1'b1;
    #1;
    n_cmp++;
    if (dout !== exp_pre) begin
      n_fail++;
      $display("FAIL same_cycle_pre got=%h exp=%h", dout, exp_pre);
    end
    @(posedge clk);
    model[2] = 16'h1234;
    #1;
    load = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 16'h1234) begin
      n_fail++;
      $display("FAIL same_cycle_post got=%h exp=1234", dout);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    address = 3'd5;
    din     = 16'hFFFF;
    load    = 1'b1;
    rst_n   = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_priority addr=5 got=%h exp=0000", dout);
    end
    // First edge with rst_n high must already accept a write.
    do_write(3'd5, 16'h1357);
    address = 3'd5;
    #1;
    n_cmp++;
    if (dout !== 16'h1357) begin
      n_fail++;
      $display("FAIL reset_release_write got=%h exp=1357", dout);
    end
  endtask

  task automatic test_hold_random();
    for (int k = 0; k < 8; k++) do_write(3'(k), 16'($urandom));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      load = 1'b0;
      din  = 16'($urandom);
      address = (c % 10 == 0) ? 3'bxxx : 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_cmp++;
      if (dout !== model[a]) begin
        n_fail++;
        $display("FAIL hold addr=%0d got=%h exp=%h", a, dout, model[a]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      address = 3'($urandom_range(0, 7));
      din     = 16'($urandom);
      load    = 1'($urandom_range(0, 1));
      #1;
      e = exp_out(address, load, din);
      n_cmp++;
      if (dout !== e) begin
        n_fail++;
        $display("FAIL random c=%0d addr=%0d ld=%0b got=%h exp=%h", c, address, load, dout, e);
      end
      @(posedge clk);
      if (load) model[address] = din;
    end
    @(negedge clk);
    load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_cmp++;
      if (dout !== model[a]) begin
        n_fail++;
        $display("FAIL random_final addr=%0d got=%h exp=%h", a, dout, model[a]);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    load    = 1'b0;
    din     = '0;
    address = '0;
    test_reset();
    test_fill();
    test_isolation();
    test_same_cycle();
    test_reset_priority();
    test_hold_random();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
